// File: rtl/core_pkg.sv
// Core-wide shared types. The MEM stage adds the access-size encoding and a
// helper that resolves the effective access size of a MEM-stage phase.
package core_pkg;

  typedef enum logic [1:0] {
    CTRL_ALU    = 2'd0,
    CTRL_MEM    = 2'd1,
    CTRL_AMO    = 2'd2,
    CTRL_BRANCH = 2'd3
  } ctrl_path_e;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  // AMO accesses always move a full word, regardless of the size field.
  function automatic mem_size_e mem_eff_size(input ctrl_path_e path, input mem_size_e size);
    return (path == CTRL_AMO) ? MEM_W : size;
  endfunction

endpackage

// File: rtl/core_mem_align.sv
// Byte-lane steering for the MEM stage: store strobes, store-data lane
// replication, misalignment detection and load shift/extension.
// Purely combinational.
module core_mem_align
  import core_pkg::*;
(
  input  mem_size_e   i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_write,
  input  logic [31:0] i_wdata,
  input  mem_size_e   i_ld_size,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  output logic [31:0] o_rdata
);

  logic [3:0]  w_strb_base;
  logic [31:0] w_shifted;

  // Request side: lane pattern, replicated write data and alignment check.
  always_comb begin
    w_strb_base  = 4'b1111;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    o_wstrb      = 4'b0000;
    case (i_size)
      MEM_B: begin
        w_strb_base = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_wdata[7:0]}};
      end
      MEM_H: begin
        w_strb_base  = 4'b0011 << i_addr_lo;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_addr_lo[0];
      end
      default: begin
        w_strb_base  = 4'b1111;
        o_misaligned = |i_addr_lo;
      end
    endcase
    if (i_write) begin
      o_wstrb = w_strb_base;
    end
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    w_shifted = i_rdata >> {i_ld_addr_lo, 3'b000};
    case (i_ld_size)
      MEM_B:   o_rdata = {{24{~i_ld_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      MEM_H:   o_rdata = {{16{~i_ld_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: o_rdata = w_shifted;
    endcase
  end

endmodule

// File: rtl/core_mem_stage.sv
// MEM-stage responder: takes one load/store/AMO phase per valid/ready
// handshake, runs a single data-bus transaction and pulses ready on completion.
// Optional bus-ack watchdog enabled by defining CORE_MEM_TIMEOUT_EN.
module core_mem_stage
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_stage_valid,
  output logic        mem_stage_ready,
  input  logic        exec_phase,
  input  ctrl_path_e  ctrl_path,
  input  logic        mem_write,
  input  mem_size_e   mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e      r_state, w_state_nxt;
  logic        r_bus_we, r_fault, r_ld_unsigned;
  logic [31:0] r_bus_addr, r_bus_wdata, r_rdata;
  logic [3:0]  r_bus_wstrb;
  logic [1:0]  r_ld_addr_lo;
  mem_size_e   r_ld_size;

  mem_size_e   w_size;
  logic        w_write, w_misaligned, w_launch, w_misal_fault, w_timeout;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_ld_data;

  assign w_size  = mem_eff_size(ctrl_path, mem_size);
  assign w_write = (ctrl_path == CTRL_AMO) ? exec_phase : mem_write;

  core_mem_align u_align (
    .i_size        (w_size),
    .i_addr_lo     (mem_addr[1:0]),
    .i_write       (w_write),
    .i_wdata       (mem_wdata),
    .i_ld_size     (r_ld_size),
    .i_ld_addr_lo  (r_ld_addr_lo),
    .i_ld_unsigned (r_ld_unsigned),
    .i_rdata       (bus_rdata),
    .o_wstrb       (w_wstrb),
    .o_wdata       (w_wdata),
    .o_misaligned  (w_misaligned),
    .o_rdata       (w_ld_data)
  );

`ifdef CORE_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  // Count REQ cycles spent waiting for ack; restart on every launch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_launch) begin
      r_wait_cnt <= '0;
    end else if (r_state == REQ && !bus_ack) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Expiry on the wait cycle that brings the count to the limit; ack wins.
  assign w_timeout = (r_state == REQ) && !bus_ack &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_launch      = 1'b0;
    w_misal_fault = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_stage_valid) begin
          if (w_misaligned) begin
            w_state_nxt   = RESP;
            w_misal_fault = 1'b1;
          end else begin
            w_state_nxt = REQ;
            w_launch    = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus_ack || w_timeout) w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus request fields and load-extension context, latched at launch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bus_we      <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_wstrb   <= '0;
      r_bus_wdata   <= '0;
      r_ld_size     <= MEM_B;
      r_ld_addr_lo  <= '0;
      r_ld_unsigned <= 1'b0;
    end else if (w_launch) begin
      r_bus_we      <= w_write;
      r_bus_addr    <= {mem_addr[31:2], 2'b00};
      r_bus_wstrb   <= w_wstrb;
      r_bus_wdata   <= w_wdata;
      r_ld_size     <= w_size;
      r_ld_addr_lo  <= mem_addr[1:0];
      r_ld_unsigned <= mem_unsigned;
    end
  end

  // Completion status and load result; load data changes only on clean reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
      r_rdata <= '0;
    end else if (w_misal_fault) begin
      r_fault <= 1'b1;
    end else if (w_launch) begin
      r_fault <= 1'b0;
    end else if (r_state == REQ && bus_ack) begin
      r_fault <= bus_err;
      if (!r_bus_we && !bus_err) r_rdata <= w_ld_data;
    end else if (w_timeout) begin
      r_fault <= 1'b1;
    end
  end

  assign bus_req         = (r_state == REQ);
  assign bus_we          = r_bus_we;
  assign bus_addr        = r_bus_addr;
  assign bus_wstrb       = r_bus_wstrb;
  assign bus_wdata       = r_bus_wdata;
  assign mem_stage_ready = (r_state == RESP);
  assign mem_fault       = r_fault && (r_state == RESP);
  assign mem_rdata       = r_rdata;

  a_valid_held_in_req: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == REQ) |-> mem_stage_valid);

endmodule

// File: tb/tb_core_mem_stage.sv
// Directed bench for core_mem_stage with a transaction-level reference model
// and a single per-cycle compare process.
module tb_core_mem_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_stage_valid, mem_stage_ready, exec_phase;
  ctrl_path_e  ctrl_path;
  logic        mem_write, mem_unsigned;
  mem_size_e   mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_fault, bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  always #5 clk = ~clk;

  core_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_stage_valid(mem_stage_valid), .mem_stage_ready(mem_stage_ready),
    .exec_phase(exec_phase), .ctrl_path(ctrl_path), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_fault(mem_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        misal;
    logic        fault;
    logic        read;
    logic [31:0] ld;
  } exp_t;

  // Expectations for the phase in flight (written by the driver only).
  exp_t        m_exp;
  // Hand-computed pins for the phase in flight.
  logic        lit_en, lit_fault, lit_rd_en, lit_bus_en, lit_we;
  int          lit_lat;
  logic [31:0] lit_rd, lit_addr, lit_wdata;
  logic [3:0]  lit_strb;

  // Compare-process state.
  logic [31:0] m_rdata;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cmp_vcnt = 0;
  logic        cmp_rp, cmp_prev_v, cmp_seen;

  // Reference model: byte-level view of the access derived from the rules.
  function automatic exp_t model(input ctrl_path_e cp, input logic wr, input logic ph,
                                 input mem_size_e sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rd, input logic err, input logic tmo);
    exp_t e;
    int nb, off;
    logic [31:0] v;
    nb  = (cp == CTRL_AMO) ? 4 : (sz == MEM_B) ? 1 : (sz == MEM_H) ? 2 : 4;
    off = int'(addr[1:0]);
    e.we    = (cp == CTRL_AMO) ? ph : wr;
    e.misal = (off % nb) != 0;
    e.addr  = addr & 32'hFFFF_FFFC;
    e.strb  = 4'b0000;
    e.wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (e.we && i >= off && i < off + nb) e.strb[i] = 1'b1;
      e.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
    end
    v = 32'h0;
    for (int k = 0; k < nb; k++) begin
      if (off + k < 4) v[8*k +: 8] = rd[8*(off+k) +: 8];
    end
    if (nb < 4 && !uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    e.ld    = v;
    e.read  = !e.we;
    e.fault = e.misal || err || tmo;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    cmp_prev_v = 1'b0;
    cmp_seen   = 1'b0;
    m_rdata    = 32'h0;
    forever begin
      @(posedge clk);
      cmp_rp = rst_n;
      @(negedge clk);
      if (!cmp_rp) begin
        m_rdata    = 32'h0;
        cmp_vcnt   = 0;
        cmp_prev_v = 1'b0;
        cmp_seen   = 1'b0;
        chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst_ready", {31'h0, mem_stage_ready}, 32'h0);
        chk("rst_fault", {31'h0, mem_fault}, 32'h0);
        chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
      end else if (rst_n) begin
        if (mem_stage_valid) cmp_vcnt++;
        else                 cmp_vcnt = 0;
        if (cmp_prev_v && !mem_stage_valid) chk("ready_seen", {31'h0, cmp_seen}, 32'h1);
        if (!cmp_prev_v && mem_stage_valid) cmp_seen = 1'b0;
        if (!mem_stage_valid) begin
          chk("idle_no_req", {31'h0, bus_req}, 32'h0);
          chk("idle_no_ready", {31'h0, mem_stage_ready}, 32'h0);
        end else if (m_exp.misal) begin
          chk("misal_no_req", {31'h0, bus_req}, 32'h0);
        end
        if (bus_req && mem_stage_valid && !m_exp.misal) begin
          chk("bus_addr", bus_addr, m_exp.addr);
          chk("bus_we", {31'h0, bus_we}, {31'h0, m_exp.we});
          chk("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, m_exp.strb});
          chk("bus_wdata", bus_wdata, m_exp.wdata);
          if (lit_bus_en) begin
            chk("lit_bus_addr", bus_addr, lit_addr);
            chk("lit_bus_we", {31'h0, bus_we}, {31'h0, lit_we});
            chk("lit_bus_wstrb", {28'h0, bus_wstrb}, {28'h0, lit_strb});
            chk("lit_bus_wdata", bus_wdata, lit_wdata);
          end
        end
        if (mem_stage_ready && mem_stage_valid) begin
          cmp_seen = 1'b1;
          chk("fault", {31'h0, mem_fault}, {31'h0, m_exp.fault});
          if (m_exp.read && !m_exp.fault) m_rdata = m_exp.ld;
          if (lit_en) begin
            chk("lit_latency", cmp_vcnt, lit_lat);
            chk("lit_fault", {31'h0, mem_fault}, {31'h0, lit_fault});
          end
          if (lit_rd_en) chk("lit_rdata", mem_rdata, lit_rd);
        end
        chk("rdata", mem_rdata, m_rdata);
        cmp_prev_v = mem_stage_valid;
      end
    end
  end

  task automatic set_lit(input int lat, input logic flt, input logic rd_en, input logic [31:0] rd,
                         input logic bus_en, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] wd, input logic we);
    lit_en = (lat != 0); lit_lat = lat; lit_fault = flt;
    lit_rd_en = rd_en; lit_rd = rd;
    lit_bus_en = bus_en; lit_addr = a; lit_strb = s; lit_wdata = wd; lit_we = we;
  endtask

  // One MEM-stage phase; dly = REQ cycles before ack, negative = never ack.
  task automatic run(input ctrl_path_e cp, input logic wr, input logic ph, input mem_size_e sz,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                     input int dly, input logic [31:0] rd, input logic err);
    int n;
    m_exp = model(cp, wr, ph, sz, uns, addr, wd, rd, err, dly < 0);
    ctrl_path = cp; mem_write = wr; exec_phase = ph; mem_size = sz;
    mem_unsigned = uns; mem_addr = addr; mem_wdata = wd;
    mem_stage_valid = 1'b1;
    if (!m_exp.misal) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus_req && n < 20);
      if (dly >= 0) begin
        repeat (dly) begin @(posedge clk); #1; end
        bus_ack = 1'b1; bus_rdata = rd; bus_err = err;
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A; bus_err = 1'b0;
      end
    end
    n = 0;
    while (!mem_stage_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    mem_stage_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst_n = 1'b0; mem_stage_valid = 1'b0; exec_phase = 1'b0; ctrl_path = CTRL_MEM;
    mem_write = 1'b0; mem_size = MEM_W; mem_unsigned = 1'b0; mem_addr = 32'h0;
    mem_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
    m_exp = model(CTRL_MEM, 1'b0, 1'b0, MEM_W, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_lit(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned LW, ack after 2 wait cycles.
    set_lit(5, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h100, 4'h0, 32'h0, 1'b0);
    run(CTRL_MEM, 1'b0, 1'b0, MEM_W, 1'b0, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
    // LB / LBU from the top lane.
    set_lit(3, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b1, 32'h100, 4'h0, 32'h0, 1'b0);
    run(CTRL_MEM, 1'b0, 1'b0, MEM_B, 1'b0, 32'h103, 32'h0, 0, 32'h80FF_FF00, 1'b0);
    set_lit(3, 1'b0, 1'b1, 32'h0000_0080, 1'b1, 32'h100, 4'h0, 32'h0, 1'b0);
    run(CTRL_MEM, 1'b0, 1'b0, MEM_B, 1'b1, 32'h103, 32'h0, 0, 32'h80FF_FF00, 1'b0);
    // SH to the upper half.
    set_lit(4, 1'b0, 1'b1, 32'h0000_0080, 1'b1, 32'h200, 4'b1100, 32'h1234_1234, 1'b1);
    run(CTRL_MEM, 1'b1, 1'b0, MEM_H, 1'b0, 32'h202, 32'h0000_1234, 1, 32'h0, 1'b0);
    // Misaligned LW, then bus error on SW.
    set_lit(2, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    run(CTRL_MEM, 1'b0, 1'b0, MEM_W, 1'b0, 32'h101, 32'h0, 0, 32'h0, 1'b0);
    set_lit(3, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 32'h104, 4'hF, 32'hCAFE_F00D, 1'b1);
    run(CTRL_MEM, 1'b1, 1'b0, MEM_W, 1'b0, 32'h104, 32'hCAFE_F00D, 0, 32'h0, 1'b1);
    // AMO read then write phase; size field is ignored for AMO.
    set_lit(3, 1'b0, 1'b1, 32'h0000_0005, 1'b1, 32'h300, 4'h0, 32'h0000_0006, 1'b0);
    run(CTRL_AMO, 1'b0, 1'b0, MEM_B, 1'b0, 32'h300, 32'h6, 0, 32'h0000_0005, 1'b0);
    set_lit(3, 1'b0, 1'b1, 32'h0000_0005, 1'b1, 32'h300, 4'hF, 32'h0000_0006, 1'b1);
    run(CTRL_AMO, 1'b0, 1'b1, MEM_B, 1'b0, 32'h300, 32'h6, 0, 32'h0, 1'b0);
    set_lit(2, 1'b1, 1'b1, 32'h0000_0005, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    run(CTRL_AMO, 1'b0, 1'b0, MEM_B, 1'b0, 32'h302, 32'h6, 0, 32'h0, 1'b0);
    // LH / LHU from the upper half.
    set_lit(3, 1'b0, 1'b1, 32'hFFFF_8001, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    run(CTRL_MEM, 1'b0, 1'b0, MEM_H, 1'b0, 32'h102, 32'h0, 0, 32'h8001_0000, 1'b0);
    set_lit(3, 1'b0, 1'b1, 32'h0000_8001, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    run(CTRL_MEM, 1'b0, 1'b0, MEM_H, 1'b1, 32'h102, 32'h0, 0, 32'h8001_0000, 1'b0);
    // SB to lane 1, misaligned SH.
    set_lit(3, 1'b0, 1'b1, 32'h0000_8001, 1'b1, 32'h100, 4'b0010, 32'hABAB_ABAB, 1'b1);
    run(CTRL_MEM, 1'b1, 1'b0, MEM_B, 1'b0, 32'h101, 32'h0000_00AB, 0, 32'h0, 1'b0);
    set_lit(2, 1'b1, 1'b1, 32'h0000_8001, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    run(CTRL_MEM, 1'b1, 1'b0, MEM_H, 1'b0, 32'h201, 32'h0, 0, 32'h0, 1'b0);
    // LW with mem_unsigned set, then a read that errors.
    set_lit(3, 1'b0, 1'b1, 32'h8000_0001, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    run(CTRL_MEM, 1'b0, 1'b0, MEM_W, 1'b1, 32'h104, 32'h0, 0, 32'h8000_0001, 1'b0);
    set_lit(3, 1'b1, 1'b1, 32'h8000_0001, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    run(CTRL_MEM, 1'b0, 1'b0, MEM_W, 1'b0, 32'h10C, 32'h0, 0, 32'h1111_1111, 1'b1);

    // Ack while idle is ignored.
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    repeat (2) begin @(posedge clk); #1; end
    bus_ack = 1'b0;
    @(posedge clk); #1;

    // Reset while a request is outstanding.
    m_exp = model(CTRL_MEM, 1'b0, 1'b0, MEM_W, 1'b0, 32'h400, 32'h0, 32'h0, 1'b0, 1'b0);
    set_lit(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    ctrl_path = CTRL_MEM; mem_write = 1'b0; mem_size = MEM_W; mem_addr = 32'h400;
    mem_stage_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0; mem_stage_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_lit(3, 1'b0, 1'b1, 32'h0000_007F, 1'b1, 32'h100, 4'h0, 32'h0, 1'b0);
    run(CTRL_MEM, 1'b0, 1'b0, MEM_B, 1'b0, 32'h100, 32'h0, 0, 32'h0000_007F, 1'b0);

`ifdef CORE_MEM_TIMEOUT_EN
    // No ack: watchdog fault after four wait cycles.
    set_lit(6, 1'b1, 1'b1, 32'h0000_007F, 1'b1, 32'h108, 4'h0, 32'h0, 1'b0);
    run(CTRL_MEM, 1'b0, 1'b0, MEM_W, 1'b0, 32'h108, 32'h0, -1, 32'h0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
